mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch-denied cycles before fetch is forced a grant.
REQ-002 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports if_req_valid in 1, if_req_addr in 16, if_req_ready out 1: instruction-fetch request (read only).
REQ-005 SHALL have ports if_rsp_valid out 1, if_rsp_data out 16: fetch read response.
REQ-006 SHALL have ports ls_req_valid in 1, ls_req_we in 1, ls_req_addr in 16, ls_req_wdata in 16, ls_req_ready out 1: load/store request.
REQ-007 SHALL have ports ls_rsp_valid out 1, ls_rsp_data out 16: load data or store acknowledge.
REQ-008 SHALL have ports mem_in_en out 1, mem_in_addr out 16, mem_in_data out 16: memory write port; memory writes on negedge of the same cycle.
REQ-009 SHALL have ports mem_out_en out 1, mem_out_addr out 16, mem_out_data in 16: memory read port; data registered by memory at posedge, valid the following cycle and held while mem_out_en low.

Function
REQ-010 SHALL grant at most one request per cycle; a request is accepted when valid and ready are both high.
REQ-011 SHALL drive if_req_ready and ls_req_ready combinationally from the grant decision; at most one ready high per cycle.
REQ-012 SHALL give ls priority over if, except when starve_cnt == STARVE_LIMIT, in which case if wins.
REQ-013 SHALL increment starve_cnt (saturating at STARVE_LIMIT) each cycle if_req_valid is high and fetch is not granted; SHALL clear it on a fetch grant or when if_req_valid is low.
REQ-014 Read grant (fetch, or ls with we=0): mem_out_en=1, mem_out_addr=request address in the grant cycle; mem_in_en=0.
REQ-015 Write grant (ls, we=1): mem_in_en=1, mem_in_addr/mem_in_data=request address/wdata in the grant cycle; mem_out_en=0.
REQ-016 No grant: mem_in_en=0, mem_out_en=0; address/data outputs SHALL be 0.
REQ-017 SHALL register a response tag (NONE/IF/LS_RD/LS_WR) at each grant; responses appear exactly one cycle after acceptance.
REQ-018 Tag IF: if_rsp_valid=1, if_rsp_data=mem_out_data for one cycle.
REQ-019 Tag LS_RD: ls_rsp_valid=1, ls_rsp_data=mem_out_data for one cycle.
REQ-020 Tag LS_WR: ls_rsp_valid=1, ls_rsp_data=0 for one cycle (store acknowledge).
REQ-021 Non-valid response data outputs SHALL be 0.
REQ-022 SHALL sustain one accepted request per cycle with no bubbles (back-to-back reads, writes, mixed).
REQ-023 A read granted the cycle after a write to the same address SHALL return the written data; no hazard logic beyond this ordering.
REQ-024 Requesters SHALL hold valid and payload stable until ready; the arbiter does not buffer unaccepted requests.

Reset
REQ-025 While rst=1: all ready, rsp_valid, mem_in_en, mem_out_en outputs 0; all data/address outputs 0.
REQ-026 Reset SHALL clear starve_cnt and response tag; a read in flight when rst asserts SHALL produce no response.
REQ-027 First grant possible in the first cycle with rst=0.

Structure
REQ-028 Package tiny16_mem_pkg SHALL hold ADDR_W=16, DATA_W=16, STARVE_LIMIT default, and the response-tag enumeration.
REQ-029 Single module, no sub-modules; the memory is instantiated by the parent, not inside mem_arbiter.

Verification
REQ-030 Fetch-only: if reads 0x0010, 0x0011 back-to-back (mem holds 0xA001, 0xA002) -> if_rsp_data 0xA001, 0xA002 on consecutive cycles, one cycle after each grant.
REQ-031 Store-then-load: ls writes 0x1234 to 0x8000, next cycle reads 0x8000 -> ack (data 0) then ls_rsp_data 0x1234.
REQ-032 Contention: both valid every cycle for 10 cycles, STARVE_LIMIT=4 -> grant pattern LS,LS,LS,LS,IF repeating; no cycle with two readies.
REQ-033 Reset mid-read: fetch granted, rst high next cycle -> if_rsp_valid stays 0; starve_cnt 0 after release.
REQ-034 Idle: no valid for 5 cycles -> mem_in_en=mem_out_en=0, all rsp_valid 0, addresses 0.
REQ-035 Wrap: fetch 0xFFFF then 0x0000 -> both responses correct, addresses unextended 16-bit.

Source files
------------

// File: rtl/tiny16_mem_pkg.sv
// Shared widths and response-tag encoding for the tiny16 memory subsystem.
package tiny16_mem_pkg;
  localparam int unsigned ADDR_W           = 16;
  localparam int unsigned DATA_W           = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_IF    = 2'd1,
    TAG_LS_RD = 2'd2,
    TAG_LS_WR = 2'd3
  } rsp_tag_e;
endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: load/store has priority over fetch, with a
// starvation counter that forces a fetch grant. Responses follow grants by one cycle.
module mem_arbiter
  import tiny16_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              mem_in_en,
  output logic [ADDR_W-1:0] mem_in_addr,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_out_en,
  output logic [ADDR_W-1:0] mem_out_addr,
  input  logic [DATA_W-1:0] mem_out_data
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  rsp_tag_e         tag_q, tag_d, tag_live;
  logic             if_grant, ls_grant;

  always_comb begin
    if_grant = 1'b0;
    ls_grant = 1'b0;
    if (!rst) begin
      if (if_req_valid && (starve_q == LIMIT)) begin
        if_grant = 1'b1;
      end else if (ls_req_valid) begin
        ls_grant = 1'b1;
      end else if (if_req_valid) begin
        if_grant = 1'b1;
      end
    end
  end

  assign if_req_ready = if_grant;
  assign ls_req_ready = ls_grant;

  always_comb begin
    mem_in_en    = 1'b0;
    mem_in_addr  = '0;
    mem_in_data  = '0;
    mem_out_en   = 1'b0;
    mem_out_addr = '0;
    tag_d        = TAG_NONE;
    if (if_grant) begin
      mem_out_en   = 1'b1;
      mem_out_addr = if_req_addr;
      tag_d        = TAG_IF;
    end else if (ls_grant && ls_req_we) begin
      mem_in_en    = 1'b1;
      mem_in_addr  = ls_req_addr;
      mem_in_data  = ls_req_wdata;
      tag_d        = TAG_LS_WR;
    end else if (ls_grant) begin
      mem_out_en   = 1'b1;
      mem_out_addr = ls_req_addr;
      tag_d        = TAG_LS_RD;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_valid || if_grant) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      tag_q    <= TAG_NONE;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  // Reset is synchronous, so the tag can still be live during the first rst
  // cycle; masking it here drops a read that was in flight when rst rose.
  assign tag_live = rst ? TAG_NONE : tag_q;

  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_valid = 1'b0;
    ls_rsp_data  = '0;
    case (tag_live)
      TAG_IF: begin
        if_rsp_valid = 1'b1;
        if_rsp_data  = mem_out_data;
      end
      TAG_LS_RD: begin
        ls_rsp_valid = 1'b1;
        ls_rsp_data  = mem_out_data;
      end
      TAG_LS_WR: begin
        ls_rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [15:0] if_req_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_we, ls_req_ready, ls_rsp_valid;
  logic [15:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
  logic        mem_in_en, mem_out_en;
  logic [15:0] mem_in_addr, mem_in_data, mem_out_addr;
  logic [15:0] mem_out_data = 16'h0000;

  logic [15:0] mem [0:65535];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .ls_req_valid (ls_req_valid),
    .ls_req_we    (ls_req_we),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_data  (ls_rsp_data),
    .mem_in_en    (mem_in_en),
    .mem_in_addr  (mem_in_addr),
    .mem_in_data  (mem_in_data),
    .mem_out_en   (mem_out_en),
    .mem_out_addr (mem_out_addr),
    .mem_out_data (mem_out_data)
  );

  // Memory: read data registered at posedge and held, writes at negedge.
  always @(posedge clk) if (mem_out_en) mem_out_data <= mem[mem_out_addr];
  always @(negedge clk) if (mem_in_en) mem[mem_in_addr] <= mem_in_data;

  typedef struct {
    logic        if_v;
    logic [15:0] if_a;
    logic        ls_v;
    logic        ls_we;
    logic [15:0] ls_a;
    logic [15:0] ls_d;
    logic        e_if_rdy;
    logic        e_ls_rdy;
    logic        e_in_en;
    logic [15:0] e_in_a;
    logic [15:0] e_in_d;
    logic        e_out_en;
    logic [15:0] e_out_a;
    logic        e_if_rv;
    logic [15:0] e_if_rd;
    logic        e_ls_rv;
    logic [15:0] e_ls_rd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] ia, input logic lv,
                       input logic lwe, input logic [15:0] la, input logic [15:0] ld);
    if_req_valid = iv;
    if_req_addr  = ia;
    ls_req_valid = lv;
    ls_req_we    = lwe;
    ls_req_addr  = la;
    ls_req_wdata = ld;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".if_rdy"}, {15'd0, if_req_ready}, 16'h0);
    chk({name, ".ls_rdy"}, {15'd0, ls_req_ready}, 16'h0);
    chk({name, ".if_rv"}, {15'd0, if_rsp_valid}, 16'h0);
    chk({name, ".ls_rv"}, {15'd0, ls_rsp_valid}, 16'h0);
    chk({name, ".in_en"}, {15'd0, mem_in_en}, 16'h0);
    chk({name, ".out_en"}, {15'd0, mem_out_en}, 16'h0);
    chk({name, ".in_a"}, mem_in_addr, 16'h0);
    chk({name, ".in_d"}, mem_in_data, 16'h0);
    chk({name, ".out_a"}, mem_out_addr, 16'h0);
    chk({name, ".if_rd"}, if_rsp_data, 16'h0);
    chk({name, ".ls_rd"}, ls_rsp_data, 16'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    mem[16'h0010] = 16'hA001;
    mem[16'h0011] = 16'hA002;
    mem[16'hFFFF] = 16'hBEEF;
    mem[16'h0000] = 16'hC0DE;
    mem[16'h0100] = 16'h5555;

    //           if_v if_a      ls_v we ls_a      ls_d      ifr lsr ien in_a      in_d      oen out_a     ifv if_d      lsv ls_d
    vecs[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0011, 1'b1, 16'hA001, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hA002, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h8000, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 16'hDEAD, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234};
    vecs[6]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0100, 1'b1, 16'hC0DE, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h5555};
    for (int i = 10; i < 15; i++)
      vecs[i] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};

    // Reset with both requesters asking: everything must stay quiet.
    rst = 1'b1;
    drive(1'b1, 16'h0010, 1'b1, 1'b1, 16'h4444, 16'h9999);
    next_cycle();
    #3 chk_quiet("reset0");
    next_cycle();
    #3 chk_quiet("reset1");

    // Row 0 is the first cycle with rst low and must already grant.
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      if (i == 0) rst = 1'b0;
      drive(vecs[i].if_v, vecs[i].if_a, vecs[i].ls_v, vecs[i].ls_we, vecs[i].ls_a, vecs[i].ls_d);
      #3;
      chk($sformatf("v%0d.if_rdy", i), {15'd0, if_req_ready}, {15'd0, vecs[i].e_if_rdy});
      chk($sformatf("v%0d.ls_rdy", i), {15'd0, ls_req_ready}, {15'd0, vecs[i].e_ls_rdy});
      chk($sformatf("v%0d.in_en", i), {15'd0, mem_in_en}, {15'd0, vecs[i].e_in_en});
      chk($sformatf("v%0d.in_a", i), mem_in_addr, vecs[i].e_in_a);
      chk($sformatf("v%0d.in_d", i), mem_in_data, vecs[i].e_in_d);
      chk($sformatf("v%0d.out_en", i), {15'd0, mem_out_en}, {15'd0, vecs[i].e_out_en});
      chk($sformatf("v%0d.out_a", i), mem_out_addr, vecs[i].e_out_a);
      chk($sformatf("v%0d.if_rv", i), {15'd0, if_rsp_valid}, {15'd0, vecs[i].e_if_rv});
      chk($sformatf("v%0d.if_rd", i), if_rsp_data, vecs[i].e_if_rd);
      chk($sformatf("v%0d.ls_rv", i), {15'd0, ls_rsp_valid}, {15'd0, vecs[i].e_ls_rv});
      chk($sformatf("v%0d.ls_rd", i), ls_rsp_data, vecs[i].e_ls_rd);
    end

    // Contention: LS x4 then IF, repeating, responses one cycle behind.
    begin
      logic prev_if;
      prev_if = 1'b0;
      for (int k = 0; k < 10; k++) begin
        logic exp_if;
        exp_if = ((k % 5) == 4);
        next_cycle();
        drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0100, 16'h0000);
        #3;
        chk($sformatf("cont%0d.if_rdy", k), {15'd0, if_req_ready}, {15'd0, exp_if});
        chk($sformatf("cont%0d.ls_rdy", k), {15'd0, ls_req_ready}, {15'd0, !exp_if});
        if (k > 0) begin
          chk($sformatf("cont%0d.if_rv", k), {15'd0, if_rsp_valid}, {15'd0, prev_if});
          chk($sformatf("cont%0d.ls_rv", k), {15'd0, ls_rsp_valid}, {15'd0, !prev_if});
          chk($sformatf("cont%0d.rsp_d", k), prev_if ? if_rsp_data : ls_rsp_data,
              prev_if ? 16'hA001 : 16'h5555);
        end
        prev_if = exp_if;
      end
      next_cycle();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #3;
      chk("cont_tail.if_rv", {15'd0, if_rsp_valid}, 16'h1);
      chk("cont_tail.if_rd", if_rsp_data, 16'hA001);
    end

    // Reset mid-read: the granted fetch must never respond.
    next_cycle();
    drive(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #3 chk("rmr.grant", {15'd0, if_req_ready}, 16'h1);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #3 chk_quiet("rmr.rst");
    next_cycle();
    rst = 1'b0;
    #3 chk_quiet("rmr.after");

    // Build up starvation, reset, and confirm the count restarted from zero.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0100, 16'h0000);
      #3 chk($sformatf("pre%0d.ls_rdy", k), {15'd0, ls_req_ready}, 16'h1);
    end
    next_cycle();
    rst = 1'b1;
    #3 chk_quiet("starve.rst");
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      rst = 1'b0;
      #3;
      chk($sformatf("post%0d.if_rdy", k), {15'd0, if_req_ready}, {15'd0, (k == 4)});
      chk($sformatf("post%0d.ls_rdy", k), {15'd0, ls_req_ready}, {15'd0, (k != 4)});
    end
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #3 chk("end.if_rv", {15'd0, if_rsp_valid}, 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
